// File: rtl/brick_field.sv
// brick_field: ROWS x COLS brick grid with hit-resolution FSM, score/remaining tracking and key-triggered refill.
// Define BRICK_FIELD_MULTI_HP_EN to give each row its own initial hit points; otherwise every brick has HP 1.
module brick_field #(
    parameter int ROWS         = 4,
    parameter int COLS         = 8,
    parameter int ORIGIN_X     = 0,
    parameter int ORIGIN_Y     = 32,
    parameter int BRICK_W_LOG2 = 6,
    parameter int BRICK_H_LOG2 = 4,
    parameter int HP_W         = 2
) (
    input  logic                             frame_clk,
    input  logic                             Reset,
    input  logic [15:0]                      keycode,
    input  logic [9:0]                       BallX,
    input  logic [9:0]                       BallY,
    input  logic                             Hit_Req,
    output logic                             Busy,
    output logic                             Hit_Done,
    output logic                             Hit_Valid,
    output logic [$clog2(ROWS)-1:0]          HitRow,
    output logic [$clog2(COLS)-1:0]          HitCol,
    output logic                             Brick_Broke,
    input  logic [9:0]                       DrawX,
    input  logic [9:0]                       DrawY,
    output logic                             Is_Brick,
    output logic [HP_W-1:0]                  Brick_HP,
    output logic [$clog2(ROWS*COLS+1)-1:0]   Bricks_Left,
    output logic [15:0]                      Score,
    output logic                             Field_Clear
);
    localparam int RW  = $clog2(ROWS);
    localparam int CW  = $clog2(COLS);
    localparam int NB  = ROWS * COLS;
    localparam int BLW = $clog2(NB + 1);
    localparam int IW  = (NB > 1) ? $clog2(NB) : 1;
`ifdef BRICK_FIELD_MULTI_HP_EN
    localparam int HS_W = HP_W;
`else
    localparam int HS_W = 1;
`endif
    localparam logic [10:0]    COLS_L = 11'(COLS);
    localparam logic [10:0]    ROWS_L = 11'(ROWS);
    localparam logic [BLW-1:0] NB_L   = BLW'(NB);
    localparam logic [IW-1:0]  LAST_I = IW'(NB - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, UPDATE, DONE, REFILL} state_t;
    typedef struct packed {
        logic          in_f;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } loc_t;

    function automatic logic [HS_W-1:0] init_hp(input int r);
`ifdef BRICK_FIELD_MULTI_HP_EN
        int h;
        int m;
        h = ROWS - r;
        m = (1 << HP_W) - 1;
        return HS_W'((h < m) ? h : m);
`else
        return HS_W'(r >= 0);
`endif
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] s);
        return (s == 16'hFFFF) ? s : s + 16'd1;
    endfunction

    // Signed offsets catch coordinates left of / above the grid origin.
    function automatic loc_t locate(input logic [9:0] x, input logic [9:0] y);
        logic signed [10:0] dx;
        logic signed [10:0] dy;
        logic [10:0]        cf;
        logic [10:0]        rf;
        loc_t               l;
        dx     = $signed({1'b0, x}) - $signed(11'(ORIGIN_X));
        dy     = $signed({1'b0, y}) - $signed(11'(ORIGIN_Y));
        cf     = $unsigned(dx) >> BRICK_W_LOG2;
        rf     = $unsigned(dy) >> BRICK_H_LOG2;
        l.in_f = (dx >= 0) && (dy >= 0) && (cf < COLS_L) && (rf < ROWS_L);
        l.row  = rf[RW-1:0];
        l.col  = cf[CW-1:0];
        return l;
    endfunction

    function automatic logic [IW-1:0] idx_of(input loc_t l);
        return IW'(int'(l.row) * COLS + int'(l.col));
    endfunction

    state_t          state_q, state_d;
    logic [9:0]      bx_q, by_q;
    loc_t            loc_q;
    logic [IW-1:0]   idx_q;
    logic [HS_W-1:0] hp_q [NB];
    logic [BLW-1:0]  left_q;
    logic [15:0]     score_q;
    logic            key_q, pend_q, pend_d;
    logic            valid_q, broke_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;

    logic            key_match, key_rise, refill_last;
    logic [IW-1:0]   cur_idx;
    logic [HS_W-1:0] cur_hp, pix_hp;
    logic            strike, breaks;
    loc_t            pix;
    logic            unused_key;

    assign unused_key  = ^keycode[15:8];
    assign key_match   = (keycode[7:0] == 8'h15);
    assign key_rise    = key_match && !key_q;
    assign refill_last = (state_q == REFILL) && (idx_q == LAST_I);
    assign pend_d      = key_rise ? 1'b1 : (refill_last ? 1'b0 : pend_q);

    assign cur_idx = idx_of(loc_q);
    assign cur_hp  = hp_q[cur_idx];
    assign strike  = loc_q.in_f && (cur_hp != '0);
    assign breaks  = strike && (cur_hp == HS_W'(1));

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            key_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_match;
            pend_q  <= pend_d;
        end
    end

    // A pending refill beats a simultaneous hit request, which is then dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pend_q) state_d = REFILL;
                     else if (Hit_Req) state_d = LOOKUP;
            LOOKUP:  state_d = UPDATE;
            UPDATE:  state_d = DONE;
            DONE:    state_d = IDLE;
            REFILL:  if (refill_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy     = (state_q != IDLE);
        Hit_Done = (state_q == DONE);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            bx_q    <= '0;
            by_q    <= '0;
            loc_q   <= '0;
            idx_q   <= '0;
            left_q  <= NB_L;
            score_q <= '0;
            valid_q <= 1'b0;
            broke_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            for (int i = 0; i < NB; i++) hp_q[i] <= init_hp(i / COLS);
        end else begin
            case (state_q)
                IDLE: begin
                    idx_q <= '0;
                    if (!pend_q && Hit_Req) begin
                        bx_q <= BallX;
                        by_q <= BallY;
                    end
                end
                LOOKUP: loc_q <= locate(bx_q, by_q);
                UPDATE: begin
                    valid_q <= strike;
                    broke_q <= breaks;
                    row_q   <= loc_q.row;
                    col_q   <= loc_q.col;
                    if (strike) hp_q[cur_idx] <= cur_hp - HS_W'(1);
                    if (breaks) begin
                        left_q  <= left_q - BLW'(1);
                        score_q <= sat_inc(score_q);
                    end
                end
                REFILL: begin
                    hp_q[idx_q] <= init_hp(int'(idx_q) / COLS);
                    idx_q       <= idx_q + IW'(1);
                    if (refill_last) left_q <= NB_L;
                end
                default: ;
            endcase
        end
    end

    // Pixel query path: purely combinational, zero when outside the grid.
    assign pix    = locate(DrawX, DrawY);
    assign pix_hp = pix.in_f ? hp_q[idx_of(pix)] : '0;

    assign Is_Brick    = (pix_hp != '0);
    assign Brick_HP    = HP_W'(pix_hp);
    assign Hit_Valid   = valid_q;
    assign Brick_Broke = broke_q;
    assign HitRow      = row_q;
    assign HitCol      = col_q;
    assign Bricks_Left = left_q;
    assign Score       = score_q;
    assign Field_Clear = (left_q == '0) && !Busy;
endmodule

// File: tb/tb_brick_field.sv
// tb_brick_field: scoreboard bench for brick_field; expected hit results are queued at request time.
// Follows BRICK_FIELD_MULTI_HP_EN in its brick model when that macro is defined.
module tb_brick_field;
    localparam int ROWS = 4;
    localparam int COLS = 8;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [15:0] keycode;
    logic [9:0]  BallX, BallY, DrawX, DrawY;
    logic        Hit_Req;
    logic        Busy, Hit_Done, Hit_Valid, Brick_Broke, Is_Brick, Field_Clear;
    logic [1:0]  HitRow;
    logic [2:0]  HitCol;
    logic [1:0]  Brick_HP;
    logic [5:0]  Bricks_Left;
    logic [15:0] Score;

    brick_field dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
        .BallX(BallX), .BallY(BallY), .Hit_Req(Hit_Req),
        .Busy(Busy), .Hit_Done(Hit_Done), .Hit_Valid(Hit_Valid),
        .HitRow(HitRow), .HitCol(HitCol), .Brick_Broke(Brick_Broke),
        .DrawX(DrawX), .DrawY(DrawY), .Is_Brick(Is_Brick), .Brick_HP(Brick_HP),
        .Bricks_Left(Bricks_Left), .Score(Score), .Field_Clear(Field_Clear)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        bit valid;
        bit broke;
        int row;
        int col;
        int left;
        int score;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_hp[ROWS][COLS];
    int   m_left;
    int   m_score;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_init(input int r);
`ifdef BRICK_FIELD_MULTI_HP_EN
        return ((ROWS - r) < 3) ? (ROWS - r) : 3;
`else
        return (r >= 0) ? 1 : 1;
`endif
    endfunction

    task automatic model_reset(input bit clear_score);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_hp[r][c] = m_init(r);
        m_left = ROWS * COLS;
        if (clear_score) m_score = 0;
    endtask

    task automatic model_hit(input int x, input int y, output exp_t e);
        int r, c;
        bit inf;
        c   = x / 64;
        r   = (y - 32) / 16;
        inf = (y >= 32) && (c < COLS) && (r < ROWS);
        e.valid = 0; e.broke = 0; e.row = r; e.col = c;
        if (inf && m_hp[r][c] > 0) begin
            m_hp[r][c]--;
            e.valid = 1;
            e.broke = (m_hp[r][c] == 0);
            if (e.broke) begin
                m_left--;
                m_score++;
            end
        end
        e.left = m_left; e.score = m_score;
    endtask

    // Compare every completion against the oldest queued expectation.
    always @(negedge frame_clk) begin
        if (Hit_Done) begin
            if (sb.size() == 0) check("spurious_done", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("hit_valid", Hit_Valid, e.valid);
                check("hit_broke", Brick_Broke, e.broke);
                if (e.valid) begin
                    check("hit_row", HitRow, e.row);
                    check("hit_col", HitCol, e.col);
                end
                check("hit_left", Bricks_Left, e.left);
                check("hit_score", Score, e.score);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge frame_clk);
        while (Busy && n < 200) begin
            @(negedge frame_clk);
            n++;
        end
        if (Busy) check("idle_timeout", 1, 0);
    endtask

    task automatic do_hit(input int x, input int y, input bit extra);
        exp_t e;
        wait_idle();
        model_hit(x, y, e);
        sb.push_back(e);
        BallX = 10'(x); BallY = 10'(y); Hit_Req = 1'b1;
        @(negedge frame_clk);
        check("busy_lookup", Busy, 1);
        if (extra) begin
            BallX = 10'd70; BallY = 10'd40;
        end else Hit_Req = 1'b0;
        @(negedge frame_clk);
        check("no_done_early", Hit_Done, 0);
        @(negedge frame_clk);
        check("done_latency", Hit_Done, 1);
        Hit_Req = 1'b0;
        @(negedge frame_clk);
        check("idle_after", Busy, 0);
    endtask

    task automatic pix(input int x, input int y, input int exp_is, input int exp_hp, input string tag);
        DrawX = 10'(x); DrawY = 10'(y);
        #1;
        check({tag, "_is"}, Is_Brick, exp_is);
        check({tag, "_hp"}, Brick_HP, exp_hp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int busy_cnt, rises, n;
        bit prev;
        Reset = 1'b1; keycode = '0; BallX = '0; BallY = '0; Hit_Req = 1'b0;
        DrawX = 10'd10; DrawY = 10'd40;
        model_reset(1);
        repeat (3) @(negedge frame_clk);
        Reset = 1'b0;

        check("rst_left", Bricks_Left, 32);
        check("rst_score", Score, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Hit_Done, 0);
        check("rst_valid", Hit_Valid, 0);
        check("rst_broke", Brick_Broke, 0);
        check("rst_rowcol", {HitRow, HitCol}, 0);
        check("rst_clear", Field_Clear, 0);
        pix(10, 40, 1, m_init(0), "rst_pix_in");
        pix(10, 20, 0, 0, "rst_pix_above");
        pix(512, 40, 0, 0, "rst_pix_right");

        do_hit(70, 40, 0);
        do_hit(100, 300, 1);
        repeat (6) @(negedge frame_clk);
        check("extra_req_dropped", sb.size(), 0);
        check("left_after_ignored", Bricks_Left, m_left);

        for (int k = 0; k < 4; k++) begin
            do_hit(5, 40, 0);
            pix(5, 40, (m_hp[0][0] > 0) ? 1 : 0, m_hp[0][0], "hp_track");
        end

        do_hit(511, 95, 0);
        do_hit(512, 40, 0);
        do_hit(300, 31, 0);

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                while (m_hp[r][c] > 0) do_hit(c * 64 + 5, 32 + r * 16 + 5, 0);
        repeat (2) @(negedge frame_clk);
        check("all_left", Bricks_Left, 0);
        check("all_clear", Field_Clear, 1);
        check("all_score", Score, m_score);
        pix(10, 40, 0, 0, "empty_pix");

        busy_cnt = 0; rises = 0; prev = 0;
        keycode = 16'h0015;
        for (int i = 0; i < 100; i++) begin
            @(negedge frame_clk);
            if (Busy) busy_cnt++;
            if (Busy && !prev) rises++;
            if (Busy) check("refill_clear_low", Field_Clear, 0);
            prev = Busy;
            if (busy_cnt == 2 && Busy && prev) begin
                pix(10, 40, 1, m_init(0), "partial_first");
                pix(453, 85, 0, 0, "partial_last");
            end
        end
        model_reset(0);
        check("refill_cycles", busy_cnt, 32);
        check("refill_once", rises, 1);
        check("refill_left", Bricks_Left, 32);
        check("refill_score", Score, m_score);
        check("refill_clear", Field_Clear, 0);
        pix(453, 85, 1, m_init(3), "refilled_last");

        keycode = '0;
        @(negedge frame_clk);
        keycode = 16'h0015;
        n = 0;
        busy_cnt = 0;
        while (busy_cnt < 10 && n < 50) begin
            @(negedge frame_clk);
            if (Busy) busy_cnt++;
            n++;
        end
        check("refill2_started", busy_cnt, 10);
        Reset = 1'b1;
        #1;
        model_reset(1);
        check("abort_busy", Busy, 0);
        check("abort_left", Bricks_Left, 32);
        check("abort_score", Score, 0);
        keycode = '0;
        @(negedge frame_clk);
        Reset = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge frame_clk);
            if (Busy) busy_cnt++;
        end
        check("no_refill_after_rst", busy_cnt, 0);
        do_hit(70, 40, 0);
        repeat (3) @(negedge frame_clk);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
